me_iddmm_bridge: RTL and testbench
==================================

// Module: me_iddmm_bridge
// PURPOSE
//   Host-side bridge for me_iddmm_top. Accepts one full-width operand pair (x, y) via valid/ready,
//   pulses me_start, serialises x/y as K-bit beats (least-significant word first) on the core's input
//   interface, then deserialises the N-word me_result stream back into one K*N-bit response.
//   Sits between the Paillier control/AXI layer and the modular-exponentiation core.
// PARAMETERS
//   K          128  word width of the me_iddmm_top data interface (bits)
//   N          32   words per operand; operand width = K*N
//   START_GAP  10   idle cycles between the me_start pulse and the first x/y beat (>=1)
// PORTS
//   clk         in   1     clock
//   rst_n       in   1     synchronous reset, active low
//   req_valid   in   1     operand pair offered
//   req_ready   out  1     bridge can accept a request (IDLE only)
//   req_x       in   K*N   operand x
//   req_y       in   K*N   operand y
//   me_start    out  1     one-cycle start pulse to core
//   me_x        out  K     x beat to core
//   me_x_valid  out  1     x beat valid
//   me_y        out  K     y beat to core
//   me_y_valid  out  1     y beat valid
//   me_result   in   K     result word from core
//   me_valid    in   1     result word valid
//   rsp_valid   out  1     assembled result available
//   rsp_ready   in   1     consumer accepts result
//   rsp_result  out  K*N   assembled result, word 0 in bits [K-1:0]
//   busy        out  1     high in every state except IDLE
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): state=IDLE; all outputs 0 except req_ready=1; counters and shift
//     registers cleared. Reset mid-operation aborts immediately; no partial response is produced.
//   - All outputs registered. Clock has one domain; no combinational path from inputs to outputs.
//   - FSM: IDLE -> START -> GAP -> SEND -> WAIT -> COLLECT -> DONE -> IDLE.
//   - IDLE: req_ready=1. On req_valid&req_ready, latch req_x/req_y into shift registers -> START.
//   - START: me_start=1 for exactly one cycle -> GAP.
//   - GAP: count START_GAP cycles with all core outputs 0 -> SEND.
//   - SEND: N+1 consecutive beats, me_x_valid=me_y_valid=1 each cycle. Beat i (0..N-1) carries
//     word i of x/y (bits [K*i+K-1:K*i]); beat N carries zero words (pad beat, valid still high).
//     Beat counter width ceil(log2(N+2)). After beat N: valids and data drop to 0 -> WAIT.
//   - WAIT: sample me_valid; the first cycle me_valid=1 captures word 0 and enters COLLECT.
//   - COLLECT: each cycle me_valid=1 captures the next word (shift-right insertion at the top so the
//     final register holds word 0 at LSB). me_valid=0 cycles stall without capture. After N words
//     captured total -> DONE. Extra me_valid beats after N words are ignored.
//   - me_valid during IDLE/START/GAP/SEND is ignored (no capture, no state change).
//   - DONE: rsp_valid=1, rsp_result stable until rsp_valid&rsp_ready; then -> IDLE next cycle,
//     req_ready=1 from that cycle. A request cannot be accepted in the same cycle as response handoff.
//   - Latency from request accept to first beat: 1 (START) + START_GAP + 1 cycles.
// TESTING
//   - Full vector, K=128 N=32: x,y = team 4096-bit vectors -> rsp_result equals golden
//     4096'h20bd63e2...e2ff5c; exactly 33 beats seen, beat 32 zero.
//   - K=8 N=4 model core echoing x: req_x=32'h44332211 -> beats 11,22,33,44,00; me_start 1 cycle,
//     first beat 12 cycles after accept (START_GAP=10); rsp_result=32'h44332211.
//   - Stalled result stream: me_valid pattern 1,0,0,1,1,0,1 with words A1,A2,A3,A4 ->
//     rsp_result=32'hA4A3A2A1, rsp_valid rises cycle after last word.
//   - Backpressure: rsp_ready held 0 for 20 cycles -> rsp_valid/rsp_result stable, req_ready=0,
//     second req_valid not accepted until cycle after handshake.
//   - Reset mid-SEND (after beat 2): all outputs 0, req_ready=1 next cycle; new request completes cleanly.
//   - Spurious me_valid=1 during GAP and SEND -> ignored; response built only from post-SEND words.

Source files
------------

// File: rtl/me_iddmm_bridge.sv
// Host-side bridge for me_iddmm_top: latches one K*N-bit operand pair, streams it to the core
// as K-bit beats followed by a zero pad beat, then reassembles the N-word result stream.
module me_iddmm_bridge #(
  parameter int K         = 128,
  parameter int N         = 32,
  parameter int START_GAP = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [K*N-1:0] req_x,
  input  logic [K*N-1:0] req_y,
  output logic           me_start,
  output logic [K-1:0]   me_x,
  output logic           me_x_valid,
  output logic [K-1:0]   me_y,
  output logic           me_y_valid,
  input  logic [K-1:0]   me_result,
  input  logic           me_valid,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [K*N-1:0] rsp_result,
  output logic           busy
);

  localparam int W  = K * N;
  localparam int BW = $clog2(N + 2);
  localparam int GW = (START_GAP > 1) ? $clog2(START_GAP) : 1;
  localparam int CW = (N > 1) ? $clog2(N + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    GAP,
    SEND,
    WAIT,
    COLLECT,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   x_sr;
  logic [W-1:0]   y_sr;
  logic [GW-1:0]  gap_cnt;
  logic [BW-1:0]  beat_cnt;
  logic [CW-1:0]  word_cnt;

  // Operands shift right one word per beat; after N beats both registers are empty,
  // and the explicit zero select on the pad beat keeps that beat well defined anyway.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_sr       <= '0;
      y_sr       <= '0;
      gap_cnt    <= '0;
      beat_cnt   <= '0;
      word_cnt   <= '0;
      req_ready  <= 1'b1;
      me_start   <= 1'b0;
      me_x       <= '0;
      me_y       <= '0;
      me_x_valid <= 1'b0;
      me_y_valid <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            x_sr      <= req_x;
            y_sr      <= req_y;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            me_start  <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          me_start <= 1'b0;
          gap_cnt  <= '0;
          state    <= GAP;
        end
        GAP: begin
          if (gap_cnt == GW'(START_GAP - 1)) begin
            me_x       <= x_sr[K-1:0];
            me_y       <= y_sr[K-1:0];
            me_x_valid <= 1'b1;
            me_y_valid <= 1'b1;
            x_sr       <= x_sr >> K;
            y_sr       <= y_sr >> K;
            beat_cnt   <= BW'(1);
            state      <= SEND;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        SEND: begin
          if (beat_cnt == BW'(N + 1)) begin
            me_x       <= '0;
            me_y       <= '0;
            me_x_valid <= 1'b0;
            me_y_valid <= 1'b0;
            word_cnt   <= '0;
            state      <= WAIT;
          end else begin
            me_x     <= (beat_cnt == BW'(N)) ? '0 : x_sr[K-1:0];
            me_y     <= (beat_cnt == BW'(N)) ? '0 : y_sr[K-1:0];
            x_sr     <= x_sr >> K;
            y_sr     <= y_sr >> K;
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        // New words enter at the top so word 0 has reached the LSB once N are captured.
        WAIT, COLLECT: begin
          if (me_valid) begin
            rsp_result <= (rsp_result >> K) | (W'(me_result) << (W - K));
            word_cnt   <= word_cnt + 1'b1;
            if (word_cnt == CW'(N - 1)) begin
              rsp_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= COLLECT;
            end
          end
        end
        DONE: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_iddmm_bridge.sv
// Scoreboard bench for me_iddmm_bridge (K=8, N=4): a model core answers each request with
// the word-wise XOR of the beats it received, so every response should equal req_x ^ req_y.
module tb_me_iddmm_bridge;

  localparam int K         = 8;
  localparam int N         = 4;
  localparam int W         = K * N;
  localparam int START_GAP = 10;
  localparam int NTX       = 12;
  localparam int BP_TX     = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_x;
  logic [W-1:0] req_y;
  logic         me_start;
  logic [K-1:0] me_x;
  logic         me_x_valid;
  logic [K-1:0] me_y;
  logic         me_y_valid;
  logic [K-1:0] me_result;
  logic         me_valid;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         busy;

  me_iddmm_bridge #(.K(K), .N(N), .START_GAP(START_GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .me_start   (me_start),
    .me_x       (me_x),
    .me_x_valid (me_x_valid),
    .me_y       (me_y),
    .me_y_valid (me_y_valid),
    .me_result  (me_result),
    .me_valid   (me_valid),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;

  logic [2*K-1:0] exp_beats[$];
  logic [W-1:0]   exp_rsp[$];
  int             acc_q[$];
  int             issued = 0;
  int             rsp_count = 0;
  int             last_hs_idx = -10;
  int             tx_beats = 0;
  bit             abort_flag = 0;
  bit             mon_en = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: event occurred where none was expected or bound expired", name);
  endtask

  // Reference model: the core returns x^y word by word, so the whole response is x^y.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y);
    bit waited = 0;
    int t = 0;
    req_x     = x;
    req_y     = y;
    req_valid = 1'b1;
    while (!req_ready && t < 2000) begin
      waited = 1;
      @(posedge clk); #1;
      t++;
    end
    if (!req_ready) begin
      reportFail("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    acc_q.push_back(edge_cnt);
    for (int i = 0; i < N; i++) exp_beats.push_back({x[i*K +: K], y[i*K +: K]});
    exp_beats.push_back('0);
    exp_rsp.push_back(x ^ y);
    issued++;
    if (waited) checkOutput("accept_after_handshake", edge_cnt, last_hs_idx + 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int t = 0;
    while (rsp_count < issued && t < 4000) begin
      @(posedge clk); #1;
      t++;
    end
    if (rsp_count < issued) reportFail("drain_timeout");
  endtask

  // Model core: stalls and spurious me_valid strobes outside the result window.
  initial begin
    int phase = 0;
    int wi = 0;
    int pi = 0;
    int resp_tx = 0;
    bit go;
    bit pat [0:6] = '{1, 0, 0, 1, 1, 0, 1};
    logic [K-1:0] xb[$];
    logic [K-1:0] yb[$];
    me_valid  = 1'b0;
    me_result = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        phase     = 0;
        me_valid  = 1'b0;
        me_result = '0;
        xb.delete();
        yb.delete();
      end else begin
        if (me_start) begin
          phase = 1;
          wi    = 0;
          pi    = 0;
          xb.delete();
          yb.delete();
        end
        if (phase == 1 && me_x_valid) begin
          xb.push_back(me_x);
          yb.push_back(me_y);
        end else if (phase == 1 && xb.size() > 0) begin
          phase = 2;
        end
        if (phase == 3) begin
          checkOutput("rsp_valid_rise", rsp_valid, 1);
          phase = 0;
          resp_tx++;
        end
        if (phase == 2) begin
          if (resp_tx == 0) begin
            go = (pi < 7) ? pat[pi] : 1'b1;
            pi++;
          end else begin
            go = ($urandom_range(0, 2) != 0);
          end
          if (go) begin
            checkOutput("rsp_valid_early", rsp_valid, 0);
            me_valid  = 1'b1;
            me_result = xb[wi] ^ yb[wi];
            wi++;
            if (wi == N) phase = 3;
          end else begin
            me_valid  = 1'b0;
            me_result = K'($urandom);
          end
        end else begin
          me_valid  = 1'($urandom_range(0, 1));
          me_result = K'($urandom);
        end
      end
    end
  end

  // Consumer: random rsp_ready, with a 20-cycle hold-off on one response.
  initial begin
    int hold = 0;
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rsp_valid && rsp_count == BP_TX && hold < 20) begin
        rsp_ready = 1'b0;
        hold++;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  logic           prev_start = 0;
  logic           prev_xv = 0;
  logic           prev_rv = 0;
  logic           prev_rr = 0;
  logic [W-1:0]   prev_res = '0;
  logic [2*K-1:0] eb;

  // Monitor: pops expected beats and responses whenever the DUT presents them.
  always @(negedge clk) begin
    if (mon_en) begin
      if (me_start) begin
        checkOutput("me_start_width", prev_start, 0);
        if (acc_q.size() > 0) checkOutput("start_latency", edge_cnt - acc_q[0], 1);
        else reportFail("me_start_unexpected");
      end
      checkOutput("valid_pair", me_y_valid, me_x_valid);
      if (me_x_valid) begin
        if (!prev_xv) begin
          if (acc_q.size() > 0) checkOutput("first_beat_latency", edge_cnt - acc_q.pop_front(), START_GAP + 2);
          else reportFail("beat_without_accept");
        end
        if (exp_beats.size() == 0) begin
          reportFail("beat_unexpected");
        end else begin
          eb = exp_beats.pop_front();
          checkOutput("beat_x", me_x, eb[2*K-1:K]);
          checkOutput("beat_y", me_y, eb[K-1:0]);
        end
        tx_beats++;
      end else begin
        checkOutput("idle_beat_data", {me_x, me_y}, 0);
        if (prev_xv) begin
          if (!abort_flag) checkOutput("beat_count", tx_beats, N + 1);
          abort_flag = 0;
          tx_beats   = 0;
        end
      end
      if (prev_rv && !prev_rr) begin
        checkOutput("rsp_hold_valid", rsp_valid, 1);
        checkOutput("rsp_hold_data", rsp_result, prev_res);
      end
      if (rsp_valid) checkOutput("req_ready_while_rsp", req_ready, 0);
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) reportFail("rsp_unexpected");
        else checkOutput("rsp_result", rsp_result, exp_rsp.pop_front());
        last_hs_idx = edge_cnt;
        rsp_count++;
      end
      checkOutput("busy_vs_ready", busy, !req_ready);
    end
    prev_start = me_start;
    prev_xv    = me_x_valid;
    prev_rv    = rsp_valid;
    prev_rr    = rsp_ready;
    prev_res   = rsp_result;
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_me_start"}, me_start, 0);
    checkOutput({tag, "_beat"}, {me_x_valid, me_y_valid, me_x, me_y}, 0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, "_rsp_result"}, rsp_result, 0);
  endtask

  initial begin
    int t;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_x     = '0;
    req_y     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n  = 1'b1;
    mon_en = 1;

    // Echo-style first request: response words come back as A1..A4 under a stalled stream.
    applyStimulus(32'h44332211, 32'hE09080B0);
    for (int i = 1; i < NTX; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 30)) @(posedge clk);
        #1;
      end
      applyStimulus($urandom, $urandom);
    end
    waitDrain();

    // Abort mid-SEND once beats 0..2 have gone out.
    applyStimulus($urandom, $urandom);
    t = 0;
    while (tx_beats < 3 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (tx_beats < 3) reportFail("send_wait_timeout");
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkResetState("abort");
    rst_n      = 1'b1;
    abort_flag = 1;
    exp_beats.delete();
    exp_rsp.delete();
    acc_q.delete();
    issued = rsp_count;

    applyStimulus($urandom, $urandom);
    waitDrain();
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
